// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 64;

  // Bit counter width: max(1, clog2(width)).
  function automatic int sa_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only adder in the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: time-shares one full_adder cell LSB-first,
// with operand and result valid/ready handshakes.
//
//   state | meaning
//   IDLE  | ready for operands (in_ready=1)
//   RUN   | one bit per clock through the cell, cnt = bit index
//   DONE  | result held on sum/cout with out_valid=1 until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             fa_s;
  logic             fa_co;
  logic             unused_sum_lsb;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_sh_d = fa_s;
    end else begin : g_wn
      assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  // The oldest sum bit falls off the end of the shift register.
  assign unused_sum_lsb = sum_sh_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !abort) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            sum_sh_q <= sum_sh_d;
            carry_q  <= fa_co;
            if (cnt_q == CNT_LAST) begin
              // Publish the result only once complete so sum/cout never show partials.
              sum_q       <= sum_sh_d;
              cout_q      <= fa_co;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
